// File: rtl/cfar_detector_pkg.sv
// Shared constants and types for the cell-averaging CFAR detector.
package cfar_detector_pkg;

   localparam int PW          = 48;   // accumulated power word width
   localparam int N_BIN       = 512;  // range bins per frame
   localparam int G           = 2;    // guard cells per side
   localparam int R           = 8;    // reference cells per side (power of two)
   localparam int ALPHA_W     = 8;    // threshold multiplier width
   localparam int ALPHA_SHIFT = 4;    // fractional bits of alpha

   localparam int BIN_W   = $clog2(N_BIN);
   localparam int R_LOG2  = $clog2(R);
   localparam int SUM_W   = PW + R_LOG2;        // one-sided window sum
   localparam int NSUM_W  = SUM_W + 1;          // lag+lead or doubled side
   localparam int MEAN_SH = R_LOG2 + 1;         // divide by 2R
   localparam int PROD_W  = NSUM_W + ALPHA_W;   // full-width mean*alpha
   localparam int L_LEN   = 2 * (G + R) + 1;    // delay line length
   localparam int CUT_IDX = G + R;              // centre cell of the line

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_FLUSH
   } state_e;

endpackage

// File: rtl/cfar_detector_window_sum.sv
// Delay line with incrementally maintained lag and lead reference sums.
// Exposes the post-advance (next-state) CUT and sums so the top can
// register a result in the same cycle the window moves.
module cfar_detector_window_sum
   import cfar_detector_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             adv_i,
   input  logic [PW-1:0]    din_i,
   output logic [PW-1:0]    cut_nxt_o,
   output logic [SUM_W-1:0] lag_nxt_o,
   output logic [SUM_W-1:0] lead_nxt_o
);

   logic [PW-1:0]    line_q [L_LEN];
   logic [PW-1:0]    line_d [L_LEN];
   logic [PW-1:0]    base   [L_LEN];
   logic [SUM_W-1:0] lag_q, lag_d, lag_b;
   logic [SUM_W-1:0] lead_q, lead_d, lead_b;

   // Clear (frame restart) first, then optionally shift one cell; the sums
   // gain the cell entering each side and lose the one leaving it.
   always_comb begin
      for (int i = 0; i < L_LEN; i++) begin
         base[i] = clear_i ? '0 : line_q[i];
      end
      lag_b  = clear_i ? '0 : lag_q;
      lead_b = clear_i ? '0 : lead_q;
      line_d = base;
      lag_d  = lag_b;
      lead_d = lead_b;
      if (adv_i) begin
         line_d[0] = din_i;
         for (int i = 1; i < L_LEN; i++) begin
            line_d[i] = base[i-1];
         end
         lead_d = lead_b + SUM_W'(din_i) - SUM_W'(base[R-1]);
         lag_d  = lag_b + SUM_W'(base[CUT_IDX+G]) - SUM_W'(base[L_LEN-1]);
      end
   end

   // Window state; cleared cells read as zero so missing edge bins add nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < L_LEN; i++) begin
            line_q[i] <= '0;
         end
         lag_q  <= '0;
         lead_q <= '0;
      end else begin
         line_q <= line_d;
         lag_q  <= lag_d;
         lead_q <= lead_d;
      end
   end

   assign cut_nxt_o  = line_d[CUT_IDX];
   assign lag_nxt_o  = lag_d;
   assign lead_nxt_o = lead_d;

endmodule

// File: rtl/cfar_detector.sv
// Cell-averaging CFAR detector: frame FSM, adaptive threshold and compare.
module cfar_detector
   import cfar_detector_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic [PW-1:0]      pwr_in,
   input  logic               pwr_valid,
   output logic               in_ready,
   input  logic [ALPHA_W-1:0] alpha,
   output logic               det_valid,
   output logic               det_flag,
   output logic [BIN_W-1:0]   det_bin,
   output logic [PW-1:0]      det_pwr,
   output logic [PW-1:0]      det_thresh,
   output logic               frame_done
);

   state_e             state_q;
   logic [BIN_W-1:0]   in_cnt_q;
   logic [BIN_W-1:0]   out_bin_q;
   logic [ALPHA_W-1:0] alpha_q;

   logic               det_valid_q, det_flag_q, frame_done_q;
   logic [BIN_W-1:0]   det_bin_q;
   logic [PW-1:0]      det_pwr_q, det_thresh_q;

   logic               accept, clear, adv, emit;
   logic [PW-1:0]      din;
   logic [PW-1:0]      cut_nxt;
   logic [SUM_W-1:0]   lag_nxt, lead_nxt;

   logic               lag_inc, lead_inc, cut_gt;
   logic [NSUM_W-1:0]  noise_sum, mean;
   logic [PROD_W-1:0]  prod, thr_full;

   // Clamp a full-width threshold to the output word.
   function automatic logic [PW-1:0] sat_thresh(input logic [PROD_W-1:0] v);
      if (|v[PROD_W-1:PW]) begin
         return '1;
      end
      return v[PW-1:0];
   endfunction

   cfar_detector_window_sum u_win (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear),
      .adv_i      (adv),
      .din_i      (din),
      .cut_nxt_o  (cut_nxt),
      .lag_nxt_o  (lag_nxt),
      .lead_nxt_o (lead_nxt)
   );

   // Per-cycle control: when the window advances and whether a CUT is ready.
   always_comb begin
      in_ready = (state_q != ST_FLUSH);
      accept   = pwr_valid && in_ready;
      clear    = frame_start;
      adv      = 1'b0;
      emit     = 1'b0;
      din      = pwr_in;
      if (frame_start) begin
         adv = accept;
      end else begin
         case (state_q)
            ST_FILL, ST_RUN: begin
               adv  = accept;
               emit = accept && (in_cnt_q >= BIN_W'(G + R));
            end
            ST_FLUSH: begin
               adv  = 1'b1;
               emit = 1'b1;
               din  = '0;
            end
            default: ;
         endcase
      end
   end

   // Noise estimate with edge doubling, then scaled threshold and strict compare.
   always_comb begin
      lag_inc  = (out_bin_q < BIN_W'(G + R));
      lead_inc = (out_bin_q > BIN_W'(N_BIN - 1 - G - R));
      if (lag_inc) begin
         noise_sum = {lead_nxt, 1'b0};
      end else if (lead_inc) begin
         noise_sum = {lag_nxt, 1'b0};
      end else begin
         noise_sum = {1'b0, lag_nxt} + {1'b0, lead_nxt};
      end
      mean     = noise_sum >> MEAN_SH;
      prod     = PROD_W'(mean) * PROD_W'(alpha_q);
      thr_full = prod >> ALPHA_SHIFT;
      cut_gt   = (PROD_W'(cut_nxt) > thr_full);
   end

   // Frame FSM, bin counters and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         in_cnt_q     <= '0;
         out_bin_q    <= '0;
         alpha_q      <= '0;
         det_valid_q  <= 1'b0;
         det_flag_q   <= 1'b0;
         det_bin_q    <= '0;
         det_pwr_q    <= '0;
         det_thresh_q <= '0;
         frame_done_q <= 1'b0;
      end else begin
         det_valid_q  <= emit;
         frame_done_q <= emit && (out_bin_q == BIN_W'(N_BIN - 1));
         if (emit) begin
            det_bin_q    <= out_bin_q;
            det_pwr_q    <= cut_nxt;
            det_thresh_q <= sat_thresh(thr_full);
            det_flag_q   <= cut_gt;
            out_bin_q    <= out_bin_q + 1'b1;
         end
         if (frame_start) begin
            state_q   <= ST_FILL;
            alpha_q   <= alpha;
            in_cnt_q  <= accept ? BIN_W'(1) : '0;
            out_bin_q <= '0;
         end else begin
            case (state_q)
               ST_FILL: begin
                  if (accept) begin
                     in_cnt_q <= in_cnt_q + 1'b1;
                     if (in_cnt_q == BIN_W'(G + R)) begin
                        state_q <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  if (accept) begin
                     in_cnt_q <= in_cnt_q + 1'b1;
                     if (in_cnt_q == BIN_W'(N_BIN - 1)) begin
                        state_q <= ST_FLUSH;
                     end
                  end
               end
               ST_FLUSH: begin
                  if (out_bin_q == BIN_W'(N_BIN - 1)) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign det_valid  = det_valid_q;
   assign det_flag   = det_flag_q;
   assign det_bin    = det_bin_q;
   assign det_pwr    = det_pwr_q;
   assign det_thresh = det_thresh_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cfar_detector.sv
// Scoreboard bench for cfar_detector: a reference model queues the expected
// result of every bin and a monitor pops and compares each DUT result.
module tb_cfar_detector;

   localparam int NB  = 512;
   localparam int GC  = 2;
   localparam int RC  = 8;
   localparam logic [47:0] MAXP = 48'hFFFF_FFFF_FFFF;

   typedef struct {
      int          bin;
      logic [47:0] pwr;
      logic [47:0] thr;
      logic        flag;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic [47:0] pwr_in;
   logic        pwr_valid;
   logic        in_ready;
   logic [7:0]  alpha;
   logic        det_valid;
   logic        det_flag;
   logic [8:0]  det_bin;
   logic [47:0] det_pwr;
   logic [47:0] det_thresh;
   logic        frame_done;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [47:0] frame_pwr [NB];
   int          checks = 0;
   int          failures = 0;
   int          res_cnt = 0;
   int          flag_cnt = 0;
   int          done_cnt = 0;

   cfar_detector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .pwr_in      (pwr_in),
      .pwr_valid   (pwr_valid),
      .in_ready    (in_ready),
      .alpha       (alpha),
      .det_valid   (det_valid),
      .det_flag    (det_flag),
      .det_bin     (det_bin),
      .det_pwr     (det_pwr),
      .det_thresh  (det_thresh),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // Reference CA-CFAR result for bin k of the current frame_pwr contents.
   function automatic exp_t model(input int k, input logic [7:0] a);
      logic [63:0] lag, lead, noise, thr;
      exp_t e;
      lag  = 0;
      lead = 0;
      for (int j = k - GC - RC; j <= k - GC - 1; j++)
         if (j >= 0) lag += 64'(frame_pwr[j]);
      for (int j = k + GC + 1; j <= k + GC + RC; j++)
         if (j < NB) lead += 64'(frame_pwr[j]);
      if (k < GC + RC)           noise = lead * 2;
      else if (k > NB-1-GC-RC)   noise = lag * 2;
      else                       noise = lag + lead;
      thr    = ((noise / (2 * RC)) * 64'(a)) / 16;
      e.bin  = k;
      e.pwr  = frame_pwr[k];
      e.thr  = (thr > 64'(MAXP)) ? MAXP : thr[47:0];
      e.flag = 64'(frame_pwr[k]) > thr;
      e.last = (k == NB - 1);
      return e;
   endfunction

   task automatic push_range(input int lo, input int hi, input logic [7:0] a);
      for (int k = lo; k <= hi; k++) sb.push_back(model(k, a));
   endtask

   task automatic fill_flat(input logic [47:0] v);
      for (int i = 0; i < NB; i++) frame_pwr[i] = v;
   endtask

   task automatic clr_counts();
      res_cnt  = 0;
      flag_cnt = 0;
      done_cnt = 0;
   endtask

   // Drives n samples of frame_pwr; frame_start rides on the first sample.
   // alpha is disturbed after the first sample since it must be latched.
   task automatic drive_frame(input int n, input bit gaps, input logic [7:0] a);
      alpha = a;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
            pwr_valid   = 1'b0;
            frame_start = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         frame_start = (i == 0);
         pwr_valid   = 1'b1;
         pwr_in      = frame_pwr[i];
         @(posedge clk);
         #1;
         if (i == 0) alpha = ~a;
      end
      frame_start = 1'b0;
      pwr_valid   = 1'b0;
      pwr_in      = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (sb.size() !== 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && det_valid) begin
         res_cnt++;
         if (det_flag)   flag_cnt++;
         if (frame_done) done_cnt++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result got bin=%0d required none", det_bin);
         end else begin
            mon_e = sb.pop_front();
            if (det_bin !== 9'(mon_e.bin)) begin
               failures++;
               $display("FAIL det_bin got=%0d required=%0d", det_bin, mon_e.bin);
            end
            checks++;
            if (det_pwr !== mon_e.pwr) begin
               failures++;
               $display("FAIL det_pwr bin=%0d got=%0d required=%0d", mon_e.bin, det_pwr, mon_e.pwr);
            end
            checks++;
            if (det_thresh !== mon_e.thr) begin
               failures++;
               $display("FAIL det_thresh bin=%0d got=%0d required=%0d", mon_e.bin, det_thresh, mon_e.thr);
            end
            checks++;
            if (det_flag !== mon_e.flag) begin
               failures++;
               $display("FAIL det_flag bin=%0d got=%0b required=%0b", mon_e.bin, det_flag, mon_e.flag);
            end
            checks++;
            if (frame_done !== mon_e.last) begin
               failures++;
               $display("FAIL frame_done bin=%0d got=%0b required=%0b", mon_e.bin, frame_done, mon_e.last);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n       = 1'b0;
      frame_start = 1'b0;
      pwr_valid   = 1'b0;
      pwr_in      = '0;
      alpha       = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({det_valid, det_flag, frame_done, in_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL reset_ctrl got=%b required=0001", {det_valid, det_flag, frame_done, in_ready});
      end
      checks++;
      if ({det_bin, det_pwr, det_thresh} !== '0) begin
         failures++;
         $display("FAIL reset_data got bin=%0d pwr=%0d thr=%0d required 0", det_bin, det_pwr, det_thresh);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({det_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL post_reset got=%b required=01", {det_valid, in_ready});
      end
   endtask

   task automatic test_flat();
      int low;
      clr_counts();
      fill_flat(48'd100);
      push_range(0, NB - 1, 8'd48);
      drive_frame(NB, 1'b0, 8'd48);
      low = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) break;
         low++;
      end
      checks++;
      if (low !== GC + RC) begin
         failures++;
         $display("FAIL flush_len got=%0d required=%0d", low, GC + RC);
      end
      wait_drain("flat");
      checks++;
      if (res_cnt !== NB || done_cnt !== 1 || flag_cnt !== 0) begin
         failures++;
         $display("FAIL flat_counts got res=%0d done=%0d flags=%0d required %0d 1 0", res_cnt, done_cnt, flag_cnt, NB);
      end
   endtask

   task automatic test_spike();
      clr_counts();
      fill_flat(48'd100);
      frame_pwr[200] = 48'd1000;
      push_range(0, NB - 1, 8'd48);
      drive_frame(NB, 1'b0, 8'd48);
      wait_drain("spike");
      checks++;
      if (flag_cnt !== 1) begin
         failures++;
         $display("FAIL spike_flags got=%0d required=1", flag_cnt);
      end
   endtask

   task automatic test_edges();
      clr_counts();
      fill_flat(48'd100);
      frame_pwr[0]      = 48'd1000;
      frame_pwr[NB - 1] = 48'd1000;
      push_range(0, NB - 1, 8'd48);
      drive_frame(NB, 1'b0, 8'd48);
      wait_drain("edges");
      checks++;
      if (flag_cnt !== 2) begin
         failures++;
         $display("FAIL edge_flags got=%0d required=2", flag_cnt);
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < NB; i++) frame_pwr[i] = 48'($urandom_range(1, 5000));
      for (int pass = 0; pass < 2; pass++) begin
         clr_counts();
         push_range(0, NB - 1, 8'd40);
         drive_frame(NB, pass == 1, 8'd40);
         wait_drain(pass == 1 ? "gaps" : "nogaps");
         checks++;
         if (res_cnt !== NB) begin
            failures++;
            $display("FAIL gaps_count pass=%0d got=%0d required=%0d", pass, res_cnt, NB);
         end
      end
   endtask

   task automatic test_saturation();
      clr_counts();
      fill_flat(48'h8000_0000_0000);
      frame_pwr[100] = MAXP;
      push_range(0, NB - 1, 8'h40);
      drive_frame(NB, 1'b0, 8'h40);
      wait_drain("saturation");
   endtask

   task automatic test_abort();
      clr_counts();
      for (int i = 0; i < NB; i++) frame_pwr[i] = 48'($urandom_range(50, 400));
      push_range(0, 300 - 1 - GC - RC, 8'd32);
      drive_frame(300, 1'b0, 8'd32);
      fill_flat(48'd100);
      frame_pwr[7]   = 48'd900;
      frame_pwr[400] = 48'd900;
      push_range(0, NB - 1, 8'd48);
      drive_frame(NB, 1'b0, 8'd48);
      wait_drain("abort");
      checks++;
      if (res_cnt !== 300 - GC - RC + NB || done_cnt !== 1) begin
         failures++;
         $display("FAIL abort_counts got res=%0d done=%0d required %0d 1", res_cnt, done_cnt, 300 - GC - RC + NB);
      end
   endtask

   task automatic test_reset_mid();
      fill_flat(48'd100);
      push_range(0, 200 - 1 - GC - RC, 8'd48);
      drive_frame(200, 1'b0, 8'd48);
      wait_drain("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({det_valid, det_flag, frame_done, in_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL midreset_ctrl got=%b required=0001", {det_valid, det_flag, frame_done, in_ready});
      end
      checks++;
      if ({det_bin, det_pwr, det_thresh} !== '0) begin
         failures++;
         $display("FAIL midreset_data got bin=%0d pwr=%0d thr=%0d required 0", det_bin, det_pwr, det_thresh);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Samples without frame_start land in IDLE and must produce nothing.
      clr_counts();
      for (int i = 0; i < 30; i++) begin
         pwr_valid = 1'b1;
         pwr_in    = 48'd5000;
         @(posedge clk);
         #1;
      end
      pwr_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (res_cnt !== 0) begin
         failures++;
         $display("FAIL idle_ignore got=%0d required=0", res_cnt);
      end
      clr_counts();
      fill_flat(48'd100);
      frame_pwr[50] = 48'd700;
      push_range(0, NB - 1, 8'd48);
      drive_frame(NB, 1'b0, 8'd48);
      wait_drain("after_reset");
      checks++;
      if (res_cnt !== NB || flag_cnt !== 1) begin
         failures++;
         $display("FAIL after_reset_counts got res=%0d flags=%0d required %0d 1", res_cnt, flag_cnt, NB);
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_spike();
      test_edges();
      test_gaps();
      test_saturation();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
